scoreboard_hazard_unit: RTL and testbench

//   Parametrised register scoreboard for the ID stage of the pipelined CPU; successor to the fixed load-use hazard detector.

---
 rtl/scoreboard_hazard_unit_if.sv | 33 +++
 rtl/scoreboard_hazard_unit.sv | 96 +++++++++
 tb/tb_scoreboard_hazard_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_hazard_unit_if.sv
// rtl/scoreboard_hazard_unit_if.sv - issue/response bundle between ID stage and the register scoreboard
interface scoreboard_hazard_unit_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 3
);
    logic              issue_valid_i;
    logic [ADDR_W-1:0] issue_rs_i;
    logic              issue_rs_used_i;
    logic [ADDR_W-1:0] issue_rt_i;
    logic              issue_rt_used_i;
    logic              issue_wr_i;
    logic [ADDR_W-1:0] issue_rd_i;
    logic [CNT_W-1:0]  issue_lat_i;
    logic              flush_i;
    logic              stall_o;
    logic              issue_fire_o;
    logic [CNT_W-1:0]  fwd_rs_o;
    logic [CNT_W-1:0]  fwd_rt_o;
    logic [ADDR_W:0]   busy_cnt_o;
    logic [31:0]       stall_cycles_o;

    modport master (
        output issue_valid_i, issue_rs_i, issue_rs_used_i, issue_rt_i, issue_rt_used_i,
        output issue_wr_i, issue_rd_i, issue_lat_i, flush_i,
        input  stall_o, issue_fire_o, fwd_rs_o, fwd_rt_o, busy_cnt_o, stall_cycles_o
    );

    modport slave (
        input  issue_valid_i, issue_rs_i, issue_rs_used_i, issue_rt_i, issue_rt_used_i,
        input  issue_wr_i, issue_rd_i, issue_lat_i, flush_i,
        output stall_o, issue_fire_o, fwd_rs_o, fwd_rt_o, busy_cnt_o, stall_cycles_o
    );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// rtl/scoreboard_hazard_unit.sv - per-register countdown scoreboard deciding regfile/bypass/stall in ID
module scoreboard_hazard_unit #(
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 4,
    parameter int FWD_WIN  = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    scoreboard_hazard_unit_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LAT);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic [ADDR_W:0]  busy_q;
    logic [ADDR_W:0]  busy_d;
    logic [31:0]      stall_cnt_q;
    logic [CNT_W-1:0] lat_eff;
    logic [CNT_W:0]   chk_rs;
    logic [CNT_W:0]   chk_rt;
    logic             waw;
    logic             stall;
    logic             fire;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Returns {raw_stall, fwd_tap}; a pending write inside the bypass window is forwarded, beyond it stalls.
    function automatic logic [CNT_W:0] check_operand(input logic used, input logic [ADDR_W-1:0] a,
                                                     input logic [CNT_W-1:0] c);
        logic [CNT_W:0] res;
        res = '0;
        if (used && !is_zero_reg(a) && (c != '0)) begin
            if (int'(c) <= FWD_WIN) res = {1'b0, c};
            else                    res = {1'b1, {CNT_W{1'b0}}};
        end
        return res;
    endfunction

    // Effective latency: zero means one cycle, anything above the maximum is clamped.
    always_comb begin
        lat_eff = bus.issue_lat_i;
        if (bus.issue_lat_i == '0)          lat_eff = CNT_W'(1);
        else if (bus.issue_lat_i > MAX_CNT) lat_eff = MAX_CNT;
    end

    // Hazard decision from the pre-update scoreboard; WAW stalls if the older write would land at/after ours.
    always_comb begin
        chk_rs = check_operand(bus.issue_rs_used_i, bus.issue_rs_i, cnt_q[bus.issue_rs_i]);
        chk_rt = check_operand(bus.issue_rt_used_i, bus.issue_rt_i, cnt_q[bus.issue_rt_i]);
        waw    = bus.issue_wr_i && !is_zero_reg(bus.issue_rd_i) && (cnt_q[bus.issue_rd_i] >= lat_eff);
        stall  = bus.issue_valid_i && (chk_rs[CNT_W] || chk_rt[CNT_W] || waw);
        fire   = bus.issue_valid_i && !stall && !bus.flush_i && !rst_i;
    end

    // Next countdown per register: a new write overrides the decrement; also counts busy entries.
    always_comb begin
        busy_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
            if (fire && bus.issue_wr_i && !is_zero_reg(bus.issue_rd_i) && (bus.issue_rd_i == ADDR_W'(r)))
                cnt_d[r] = lat_eff - 1'b1;
            if (cnt_d[r] != '0) busy_d = busy_d + 1'b1;
        end
    end

    // Scoreboard state and busy count move together so busy_cnt_o always matches the array.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            busy_q <= busy_d;
        end
    end

    // Saturating count of real stall cycles; flushed instructions do not count.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt_q <= '0;
        else if (bus.issue_valid_i && stall && !bus.flush_i && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.stall_o        = stall;
    assign bus.issue_fire_o   = fire;
    assign bus.fwd_rs_o       = chk_rs[CNT_W-1:0];
    assign bus.fwd_rt_o       = chk_rt[CNT_W-1:0];
    assign bus.busy_cnt_o     = busy_q;
    assign bus.stall_cycles_o = stall_cnt_q;
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb/tb_scoreboard_hazard_unit.sv - directed self-checking bench for scoreboard_hazard_unit
module tb_scoreboard_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    scoreboard_hazard_unit_if #(.ADDR_W(5), .CNT_W(3)) bus ();

    scoreboard_hazard_unit #(.ADDR_W(5), .MAX_LAT(4), .FWD_WIN(2), .ZERO_REG(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag, input logic st, input logic fi,
                            input logic [2:0] fr, input logic [2:0] ft);
        chk({tag, "_stall"}, 32'(bus.stall_o), 32'(st));
        chk({tag, "_fire"}, 32'(bus.issue_fire_o), 32'(fi));
        chk({tag, "_fwd_rs"}, 32'(bus.fwd_rs_o), 32'(fr));
        chk({tag, "_fwd_rt"}, 32'(bus.fwd_rt_o), 32'(ft));
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                         input logic rtu, input logic wr, input logic [4:0] rd, input logic [2:0] lat,
                         input logic fl);
        bus.issue_valid_i   = v;
        bus.issue_rs_i      = rs;
        bus.issue_rs_used_i = rsu;
        bus.issue_rt_i      = rt;
        bus.issue_rt_used_i = rtu;
        bus.issue_wr_i      = wr;
        bus.issue_rd_i      = rd;
        bus.issue_lat_i     = lat;
        bus.flush_i         = fl;
        #1;
    endtask

    initial begin
        // reset with garbage on the inputs
        rst = 1'b1;
        drive(1, 5'd5, 1, 5'd6, 1, 1, 5'd9, 3'd3, 0);
        chk("rst_fire", 32'(bus.issue_fire_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // S1 post-reset state
        drive(0, 0, 0, 0, 0, 0, 0, 3'd1, 0);
        chk_comb("reset", 0, 0, 0, 0);
        chk("reset_busy", 32'(bus.busy_cnt_o), 32'd0);
        chk("reset_sc", bus.stall_cycles_o, 32'd0);
        @(negedge clk);

        // load-use: r5 latency 4
        drive(1, 0, 0, 0, 0, 1, 5'd5, 3'd4, 0);
        chk_comb("lu_issue", 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 5'd5, 1, 5'd5, 1, 0, 0, 3'd1, 0);
        chk_comb("lu_cnt3", 1, 0, 0, 0);
        chk("lu_busy", 32'(bus.busy_cnt_o), 32'd1);
        chk("lu_sc0", bus.stall_cycles_o, 32'd0);
        @(negedge clk);
        drive(1, 5'd5, 1, 5'd5, 1, 0, 0, 3'd1, 0);
        chk_comb("lu_cnt2", 0, 1, 3'd2, 3'd2);
        chk("lu_sc1", bus.stall_cycles_o, 32'd1);
        @(negedge clk);
        drive(1, 5'd5, 1, 5'd5, 0, 0, 0, 3'd1, 0);
        chk_comb("lu_cnt1_rt_unused", 0, 1, 3'd1, 3'd0);
        @(negedge clk);
        drive(1, 5'd5, 1, 5'd5, 1, 0, 0, 3'd1, 0);
        chk_comb("lu_cnt0", 0, 1, 0, 0);
        chk("lu_busy0", 32'(bus.busy_cnt_o), 32'd0);
        @(negedge clk);

        // ALU chain on r2, latency 2, each reads previous result
        drive(1, 5'd2, 1, 0, 0, 1, 5'd2, 3'd2, 0);
        chk_comb("alu0", 0, 1, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drive(1, 5'd2, 1, 0, 0, 1, 5'd2, 3'd2, 0);
            chk_comb("alu_chain", 0, 1, 3'd1, 0);
            chk("alu_busy", 32'(bus.busy_cnt_o), 32'd1);
            @(negedge clk);
        end
        drive(1, 5'd2, 1, 0, 0, 0, 0, 3'd1, 0);
        chk_comb("alu_tail", 0, 1, 3'd1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 3'd1, 0);
        chk("alu_busy0", 32'(bus.busy_cnt_o), 32'd0);
        @(negedge clk);

        // WAW on r7
        drive(1, 0, 0, 0, 0, 1, 5'd7, 3'd4, 0);
        chk_comb("waw_first", 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd7, 3'd2, 0);
        chk_comb("waw_lat2_cnt3", 1, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd7, 3'd4, 0);
        chk_comb("waw_lat4_cnt2", 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd7, 3'd3, 0);
        chk_comb("waw_equal", 1, 0, 0, 0);
        @(negedge clk);
        drive(1, 5'd7, 1, 0, 0, 0, 0, 3'd1, 0);
        chk_comb("waw_read_cnt2", 0, 1, 3'd2, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 3'd1, 0);
        chk("waw_sc3", bus.stall_cycles_o, 32'd3);
        @(negedge clk);

        // latency clamp (7 -> 4) and zero latency (0 -> 1)
        drive(1, 0, 0, 0, 0, 1, 5'd9, 3'd7, 0);
        chk_comb("clamp_issue", 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 5'd9, 1, 0, 0, 0, 0, 3'd1, 0);
        chk_comb("clamp_cnt3", 1, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd10, 3'd0, 0);
        chk_comb("lat0_issue", 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 5'd10, 1, 5'd9, 1, 0, 0, 3'd1, 0);
        chk_comb("lat0_read", 0, 1, 0, 3'd1);
        chk("lat0_busy", 32'(bus.busy_cnt_o), 32'd1);
        chk("lat0_sc4", bus.stall_cycles_o, 32'd4);
        @(negedge clk);

        // register 0 is never busy
        drive(1, 0, 0, 0, 0, 1, 5'd0, 3'd4, 0);
        chk_comb("r0_write", 0, 1, 0, 0);
        @(negedge clk);
        drive(1, 5'd0, 1, 5'd0, 1, 0, 0, 3'd1, 0);
        chk_comb("r0_read", 0, 1, 0, 0);
        chk("r0_busy", 32'(bus.busy_cnt_o), 32'd0);
        @(negedge clk);

        // flush cancels issue and leaves the scoreboard untouched
        drive(1, 0, 0, 0, 0, 1, 5'd3, 3'd4, 1);
        chk_comb("flush_issue", 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 5'd3, 1, 0, 0, 0, 0, 3'd1, 0);
        chk_comb("flush_after", 0, 1, 0, 0);
        chk("flush_busy", 32'(bus.busy_cnt_o), 32'd0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd12, 3'd4, 0);
        @(negedge clk);
        drive(1, 5'd12, 1, 0, 0, 0, 0, 3'd1, 1);
        chk_comb("flush_stall", 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 3'd1, 0);
        chk("flush_sc_nocount", bus.stall_cycles_o, 32'd4);
        @(negedge clk);

        // stall counter saturation, then reset mid-stall
        drive(1, 0, 0, 0, 0, 1, 5'd11, 3'd4, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd11, 3'd1, 0);
        chk_comb("sat_stall1", 1, 0, 0, 0);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd11, 3'd1, 0);
        chk("sat_reach", bus.stall_cycles_o, 32'hFFFF_FFFF);
        chk("sat_stall2", 32'(bus.stall_o), 32'd1);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5'd11, 3'd1, 0);
        chk("sat_hold", bus.stall_cycles_o, 32'hFFFF_FFFF);
        chk("sat_busy", 32'(bus.busy_cnt_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 3'd1, 0);
        chk("midrst_sc", bus.stall_cycles_o, 32'd0);
        chk("midrst_busy", 32'(bus.busy_cnt_o), 32'd0);
        @(negedge clk);

        // reset drops pending writes and blocks fire
        drive(1, 0, 0, 0, 0, 1, 5'd4, 3'd4, 0);
        chk_comb("pend_issue", 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 5'd6, 3'd4, 0);
        chk_comb("rst_block", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 5'd4, 1, 5'd6, 1, 0, 0, 3'd1, 0);
        chk_comb("rst_dropped", 0, 1, 0, 0);
        chk("rst_dropped_busy", 32'(bus.busy_cnt_o), 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
